// File: rtl/g_prbs_pkg.sv
// g_prbs_pkg: shared types and constants for the PRBS checker.
// Holds the checker FSM state enum, PRBS-7 / PRBS-15 LFSR widths, taps and seed lengths.
// G_PRBS_CHK_PRBS15_EN selects which polynomial the active LFSR_W / TAP_* / SEED_LEN refer to.
package g_prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // PRBS-7: x^7 + x^6 + 1
  localparam int PRBS7_W        = 7;
  localparam int PRBS7_TAP_A    = 6;
  localparam int PRBS7_TAP_B    = 5;
  localparam int PRBS7_SEED_LEN = 7;

  // PRBS-15: x^15 + x^14 + 1
  localparam int PRBS15_W        = 15;
  localparam int PRBS15_TAP_A    = 14;
  localparam int PRBS15_TAP_B    = 13;
  localparam int PRBS15_SEED_LEN = 15;

`ifdef G_PRBS_CHK_PRBS15_EN
  localparam int LFSR_W   = PRBS15_W;
  localparam int TAP_A    = PRBS15_TAP_A;
  localparam int TAP_B    = PRBS15_TAP_B;
  localparam int SEED_LEN = PRBS15_SEED_LEN;
`else
  localparam int LFSR_W   = PRBS7_W;
  localparam int TAP_A    = PRBS7_TAP_A;
  localparam int TAP_B    = PRBS7_TAP_B;
  localparam int SEED_LEN = PRBS7_SEED_LEN;
`endif

endpackage

// File: rtl/g_prbs_lfsr.sv
// g_prbs_lfsr: XNOR Fibonacci LFSR that either loads serial data (seeding) or free-runs.
// Latency: state updates one clk after en; exp_bit and seed_ones are combinational on state/din.
// Backpressure: none; en=0 simply holds the register.
// Ports: clk, rst_n (async active-low), en (advance), load (1: shift din in, 0: shift exp_bit in),
//        din (serial input), exp_bit (next expected bit), seed_ones (register would become all-ones if din is loaded).
module g_prbs_lfsr #(
  parameter int W     = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  logic din,
  output logic exp_bit,
  output logic seed_ones
);

  logic [W-1:0] s;

  assign exp_bit = ~(s[TAP_A] ^ s[TAP_B]);

  // Looks one bit ahead so the FSM can reject the XNOR lockup seed on the
  // same edge that completes it.
  assign seed_ones = &{s[W-2:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (en) begin
      s <= {s[W-2:0], load ? din : exp_bit};
    end
  end

endmodule

// File: rtl/g_prbs_chk.sv
// g_prbs_chk: PRBS checker (PRBS-7 XNOR by default, PRBS-15 with G_PRBS_CHK_PRBS15_EN) with lock FSM and error count.
// Latency: LOCK/ERR/ECNT are registered, one CK after the valid bit that causes them.
// Backpressure: none; EN=0 freezes LFSR, FSM and counters (ERR reads 0).
// Ports: CK clock, RN async active-low reset, EN valid qualifier, DIN serial bit, CLR sync ECNT clear,
//        LOCK synchronised flag, ERR one-cycle error pulse, ECNT saturating error count.
module g_prbs_chk
  import g_prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ECNT_W   = 16
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              EN,
  input  logic              DIN,
  input  logic              CLR,
  output logic              LOCK,
  output logic              ERR,
  output logic [ECNT_W-1:0] ECNT
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int SW = $clog2(SEED_LEN + 1);

  localparam logic [MW-1:0]     MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0]     LOSS_LAST  = LW'(LOSS_CNT - 1);
  localparam logic [SW-1:0]     SEED_LAST  = SW'(SEED_LEN - 1);
  localparam logic [ECNT_W-1:0] ECNT_MAX   = '1;

  state_t          state;
  logic [SW-1:0]   seed_cnt;
  logic [MW-1:0]   match_cnt;
  logic [LW-1:0]   loss_cnt;

  logic            exp_bit;
  logic            seed_ones;
  logic            load;
  logic            mismatch;
  logic            err_inc;

  assign load     = (state == ST_SEED);
  assign mismatch = DIN ^ exp_bit;
  assign err_inc  = EN && (state == ST_LOCKED) && mismatch;

  g_prbs_lfsr #(
    .W     (LFSR_W),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_lfsr (
    .clk       (CK),
    .rst_n     (RN),
    .en        (EN),
    .load      (load),
    .din       (DIN),
    .exp_bit   (exp_bit),
    .seed_ones (seed_ones)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= ST_SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      loss_cnt  <= '0;
      LOCK      <= 1'b0;
      ERR       <= 1'b0;
      ECNT      <= '0;
    end else begin
      ERR <= 1'b0;

      if (EN) begin
        case (state)
          ST_SEED: begin
            if (seed_cnt == SEED_LAST) begin
              seed_cnt <= '0;
              // An all-ones seed would free-run as all-ones forever; reseed instead.
              if (!seed_ones) begin
                state     <= ST_VERIFY;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 1'b1;
            end
          end

          ST_VERIFY: begin
            if (mismatch) begin
              state     <= ST_SEED;
              seed_cnt  <= '0;
              match_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              state     <= ST_LOCKED;
              LOCK      <= 1'b1;
              match_cnt <= '0;
              loss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end

          ST_LOCKED: begin
            if (mismatch) begin
              ERR <= 1'b1;
              if (loss_cnt == LOSS_LAST) begin
                state    <= ST_SEED;
                LOCK     <= 1'b0;
                loss_cnt <= '0;
                seed_cnt <= '0;
              end else begin
                loss_cnt <= loss_cnt + 1'b1;
              end
            end else begin
              loss_cnt <= '0;
            end
          end

          default: begin
            state     <= ST_SEED;
            seed_cnt  <= '0;
            match_cnt <= '0;
            loss_cnt  <= '0;
            LOCK      <= 1'b0;
          end
        endcase
      end

      // Clear beats a coincident increment; ERR above still pulses for that bit.
      if (CLR) begin
        ECNT <= '0;
      end else if (err_inc && (ECNT != ECNT_MAX)) begin
        ECNT <= ECNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_g_prbs_chk.sv
module tb_g_prbs_chk;

  logic        CK  = 1'b0;
  logic        RN  = 1'b1;
  logic        EN  = 1'b0;
  logic        DIN = 1'b0;
  logic        CLR = 1'b0;
  logic        LOCK, ERR, LOCK4, ERR4;
  logic [15:0] ECNT;
  logic [3:0]  ECNT4;

  int checks   = 0;
  int failures = 0;

  always #5 CK = ~CK;

  g_prbs_chk u_dut (
    .CK(CK), .RN(RN), .EN(EN), .DIN(DIN), .CLR(CLR),
    .LOCK(LOCK), .ERR(ERR), .ECNT(ECNT)
  );

  g_prbs_chk #(.ECNT_W(4)) u_dut4 (
    .CK(CK), .RN(RN), .EN(EN), .DIN(DIN), .CLR(CLR),
    .LOCK(LOCK4), .ERR(ERR4), .ECNT(ECNT4)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in sequence terms: the checker's reference bit b[n] is
  // the received bit while seeding, else b[n-7] XNOR b[n-6].
  bit q[$];
  int m_mode  = 0;  // 0 seed, 1 verify, 2 locked
  int m_seed  = 0;
  int m_match = 0;
  int m_loss  = 0;
  bit m_lock  = 0;
  bit m_err   = 0;
  int m_e16   = 0;
  int m_e4    = 0;
  int m_ones;
  bit m_exp, m_bad;
  bit cmp_on  = 0;

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_mode = 0; m_seed = 0; m_match = 0; m_loss = 0;
      m_lock = 0; m_err = 0; m_e16 = 0; m_e4 = 0;
    end else begin
      m_err = 0;
      if (EN) begin
        if (m_mode == 0) begin
          q.push_back(DIN);
          if (q.size() > 7) void'(q.pop_front());
          m_seed++;
          if (m_seed == 7) begin
            m_seed = 0;
            m_ones = 0;
            foreach (q[i]) m_ones += int'(q[i]);
            if (m_ones != 7) begin
              m_mode  = 1;
              m_match = 0;
            end
          end
        end else begin
          m_exp = ~(q[0] ^ q[1]);
          m_bad = (DIN != m_exp);
          q.push_back(m_exp);
          void'(q.pop_front());
          if (m_mode == 1) begin
            if (m_bad) begin
              m_mode = 0; m_match = 0; m_seed = 0;
            end else begin
              m_match++;
              if (m_match == 16) begin
                m_mode = 2; m_lock = 1; m_match = 0; m_loss = 0;
              end
            end
          end else begin
            if (m_bad) begin
              m_err = 1;
              m_loss++;
              if (m_e16 < 65535) m_e16++;
              if (m_e4 < 15) m_e4++;
              if (m_loss == 4) begin
                m_mode = 0; m_lock = 0; m_loss = 0; m_seed = 0;
              end
            end else begin
              m_loss = 0;
            end
          end
        end
      end
      if (CLR) begin
        m_e16 = 0;
        m_e4  = 0;
      end
    end
  end

  always @(negedge CK) begin
    if (cmp_on) begin
      check("cyc_lock",  LOCK,  m_lock);
      check("cyc_err",   ERR,   m_err);
      check("cyc_ecnt",  ECNT,  m_e16);
      check("cyc_lock4", LOCK4, m_lock);
      check("cyc_err4",  ERR4,  m_err);
      check("cyc_ecnt4", ECNT4, m_e4);
    end
  end

  // Transmit-side PRBS-7 XNOR generator.
  logic [6:0] g = 7'h00;

  task automatic send(input bit flip, input bit clr);
    bit b;
    b   = ~(g[6] ^ g[5]);
    g   = {g[5:0], b};
    DIN = b ^ flip;
    EN  = 1'b1;
    CLR = clr;
    @(posedge CK);
    #1;
    EN  = 1'b0;
    CLR = 1'b0;
  endtask

  task automatic send_raw(input bit d);
    DIN = d;
    EN  = 1'b1;
    @(posedge CK);
    #1;
    EN  = 1'b0;
  endtask

  task automatic wait_lock(input int maxb, output int n);
    n = 0;
    while (!LOCK && n < maxb) begin
      send(1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    #2 RN = 1'b0;
    #1 cmp_on = 1'b1;
    check("rst_lock", LOCK, 0);
    check("rst_err",  ERR,  0);
    check("rst_ecnt", ECNT, 0);
    check("rst_ecnt4", ECNT4, 0);
    @(posedge CK);
    #1 RN = 1'b1;

    // Clean stream: lock on valid bit 23
    repeat (22) send(1'b0, 1'b0);
    check("lock_before_23", LOCK, 0);
    send(1'b0, 1'b0);
    check("lock_at_23", LOCK, 1);
    check("ecnt_clean", ECNT, 0);
    repeat (10) send(1'b0, 1'b0);
    check("err_clean", ERR, 0);

    // Single flipped bit while locked
    send(1'b1, 1'b0);
    check("single_err_pulse", ERR, 1);
    check("single_ecnt", ECNT, 1);
    check("single_lock_held", LOCK, 1);
    send(1'b0, 1'b0);
    check("single_err_drop", ERR, 0);
    check("single_ecnt_hold", ECNT, 1);

    // Four consecutive flips drop lock, then relock
    send(1'b0, 1'b1);
    check("clr_ecnt", ECNT, 0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      check("burst_err", ERR, 1);
      check("burst_lock", LOCK, (i < 3) ? 1 : 0);
    end
    check("burst_ecnt", ECNT, 4);
    check("burst_ecnt4", ECNT4, 4);
    wait_lock(40, n);
    check("relock_bits", n, 23);

    // Saturation with ECNT_W=4, then CLR coincident with an error
    send(1'b0, 1'b1);
    repeat (20) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
    end
    check("sat_ecnt4", ECNT4, 15);
    check("sat_ecnt16", ECNT, 20);
    check("sat_lock", LOCK, 1);
    send(1'b1, 1'b1);
    check("clr_err_ecnt4", ECNT4, 0);
    check("clr_err_err4", ERR4, 1);
    check("clr_err_ecnt16", ECNT, 0);
    check("clr_err_err16", ERR, 1);

    // EN low for 10 cycles while locked: nothing moves
    send(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      DIN = i[0];
      @(posedge CK);
      #1;
      check("hold_err", ERR, 0);
      check("hold_lock", LOCK, 1);
      check("hold_ecnt", ECNT, 1);
    end
    repeat (8) send(1'b0, 1'b0);
    check("hold_resume_ecnt", ECNT, 1);
    check("hold_resume_lock", LOCK, 1);

    // Asynchronous reset mid-lock, between edges
    send(1'b1, 1'b0);
    #2 RN = 1'b0;
    #1;
    check("arst_lock", LOCK, 0);
    check("arst_ecnt", ECNT, 0);
    check("arst_err",  ERR,  0);
    @(posedge CK);
    #1 RN = 1'b1;

    // All-ones seeds are rejected; seeding restarts with the next bit
    repeat (28) send_raw(1'b1);
    check("ones_no_lock", LOCK, 0);
    wait_lock(40, n);
    check("ones_relock_bits", n, 23);
    check("ones_ecnt", ECNT, 0);

    repeat (2) @(posedge CK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g_prbs_chk.md
G_PRBS_CHK -- requirements
Module: g_prbs_chk

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 16: consecutive matches needed to declare lock.
REQ-002 The block SHALL have parameter LOSS_CNT, default 4: consecutive mismatches while locked that drop lock.
REQ-003 The block SHALL have parameter ECNT_W, default 16: error counter width.
REQ-004 The block SHALL have port CK, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RN, input, width 1: asynchronous active-low reset.
REQ-006 The block SHALL have port EN, input, width 1: DIN valid qualifier.
REQ-007 The block SHALL have port DIN, input, width 1: received serial bit.
REQ-008 The block SHALL have port CLR, input, width 1: synchronous clear of ECNT.
REQ-009 The block SHALL have port LOCK, output, width 1: checker is synchronised to the stream.
REQ-010 The block SHALL have port ERR, output, width 1: one-cycle pulse per mismatched bit while locked.
REQ-011 The block SHALL have port ECNT, output, width ECNT_W: saturating error count.

Function
REQ-012 The checker SHALL track PRBS-7 in XNOR form: polynomial x^7+x^6+1; expected bit = XNOR(s[6], s[5]); all-ones is the lockup state.
REQ-013 The checker SHALL sample DIN on rising CK only when EN=1; with EN=0, LFSR, state, counters and ECNT SHALL hold, and ERR SHALL be 0 the next cycle.
REQ-014 The FSM SHALL have the states SEED, VERIFY and LOCKED.
REQ-015 In SEED, the checker SHALL shift 7 valid bits into s (s <= {s[5:0], DIN}).
REQ-016 After the 7th SEED bit, the FSM SHALL go to VERIFY, except that an all-ones seed SHALL restart SEED with the seed count at 0.
REQ-017 In VERIFY and LOCKED, s SHALL free-run as s <= {s[5:0], expected} on each valid bit, independent of DIN.
REQ-018 In VERIFY, each match SHALL increment the match count; on the LOCK_CNT-th consecutive match the FSM SHALL go to LOCKED.
REQ-019 In VERIFY, any mismatch SHALL return the FSM to SEED with counts zeroed.
REQ-020 In LOCKED, a mismatch SHALL assert ERR on the next cycle, increment ECNT and increment the loss count; a match SHALL zero the loss count.
REQ-021 In LOCKED, when the loss count reaches LOSS_CNT, the FSM SHALL go to SEED and LOCK SHALL deassert on the same edge.
REQ-022 LOCK SHALL be registered and high exactly while the FSM is in LOCKED.
REQ-023 Mismatches outside LOCKED SHALL NOT assert ERR or change ECNT.
REQ-024 ECNT SHALL saturate at all-ones and never wrap.
REQ-025 When CLR=1, ECNT SHALL be 0 next cycle; CLR SHALL win over a simultaneous error increment, and that error SHALL still pulse ERR.

Reset
REQ-026 On RN=0, the block SHALL asynchronously force FSM=SEED, s=0, all counts=0, LOCK=0, ERR=0, ECNT=0.
REQ-027 A reset mid-lock or mid-seed SHALL discard all progress; after RN rises, operation SHALL restart from the first valid bit.

Configuration
REQ-028 With macro G_PRBS_CHK_PRBS15_EN defined, the checker SHALL use PRBS-15 (x^15+x^14+1, XNOR form, expected = XNOR(s[14], s[13])), a 15-bit LFSR, a 15-bit seed and an all-ones lockup check on 15 bits.
REQ-029 Without G_PRBS_CHK_PRBS15_EN, the checker SHALL be PRBS-7 only, with no PRBS-15 logic present.

Structure
REQ-030 Package g_prbs_pkg SHALL hold the FSM state enum, the LFSR width and tap constants for PRBS-7 and PRBS-15, and the seed length constants.
REQ-031 The design SHALL use one sub-module, g_prbs_lfsr: an XNOR LFSR with load-shift (from DIN) and free-run modes, and with expected-bit and all-ones outputs.

Verification
REQ-032 The bench SHALL reset, then send a clean PRBS-7 XNOR stream with EN=1, and SHALL check that LOCK rises after valid bit 23 (7 seed + 16 matches), that ERR stays 0 and that ECNT=0.
REQ-033 The bench SHALL flip one bit while locked, and SHALL check one ERR pulse the next cycle, ECNT=1 and LOCK staying 1.
REQ-034 The bench SHALL flip 4 consecutive bits while locked, and SHALL check 4 ERR pulses, ECNT=4 and LOCK=0 after the 4th; a clean stream SHALL relock within 23 valid bits.
REQ-035 The bench SHALL build with ECNT_W=4 and inject 20 isolated errors while locked, and SHALL check that ECNT holds at 15; it SHALL then assert CLR coincident with an error and check ECNT=0 and ERR=1.
REQ-036 The bench SHALL seed with 7 ones, then stream, and SHALL check that the FSM stays in SEED for the all-ones seed, that LOCK stays 0 and that valid seeding restarts with the next bit.
REQ-037 The bench SHALL pull RN low mid-lock between CK edges, and SHALL check that LOCK=0, ECNT=0 and ERR=0 immediately; it SHALL also toggle EN=0 for 10 cycles while locked and check that no state changes.
